muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Iterative RV32M multiply/divide sequencer in the execute stage, alongside the ALU datapath.
- Takes the same SrcA/SrcB operands the ALU sees and runs one 32-iteration shift-add (multiply) or restoring (divide) operation.
- Stalls the pipeline while it runs and returns a registered result for the Result/WD3 writeback path.
- Handles signedness, divide-by-zero and signed-overflow per the RISC-V M spec.

Parameters:
- D_WIDTH, 32, operand/result width; only 32 is supported.
- CNT_WIDTH, 5, iteration counter width; equals log2(D_WIDTH).

Ports:
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous active-high reset.
- start  input  1  request a new operation; only accepted in IDLE.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  D_WIDTH  rs1 operand (dividend / multiplicand).
- SrcB  input  D_WIDTH  rs2 operand (divisor / multiplier).
- flush  input  1  abort any in-flight operation (branch/jump redirect).
- Stall  output  1  hold the pipeline (fetch/decode/execute registers).
- busy  output  1  high in CALC and DONE.
- done  output  1  one-cycle pulse; MDResult valid in this cycle.
- MDResult  output  D_WIDTH  registered result; held until the next completion.

Behaviour:
- Reset:
  - RST=1 at a clock edge forces IDLE and clears counter, internal accumulators and MDResult to 0.
  - done=0, busy=0, Stall=0 after reset.
  - RST has priority over everything and aborts mid-operation.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge where start=1 and flush=0, latch funct3, operand magnitudes and sign flags, and clear the counter.
  - If the op is DIV/DIVU/REM/REMU and SrcB==0, or DIV/REM with SrcA=0x80000000 and SrcB=0xFFFFFFFF, go to DONE directly (special case).
  - Otherwise go to CALC.
- CALC:
  - One iteration per edge; counter increments 0..31.
  - The edge that completes iteration 31 loads MDResult (sign-corrected) and moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency:
  - Normal: start sampled at edge E0, done high in the cycle after edge E32 (33 cycles after E0).
  - Special case: done high in the cycle after E0.
- Stall is combinational: (IDLE & start & ~flush) | CALC. Stall is low in DONE so the pipeline captures MDResult and advances in that cycle.
- Arithmetic:
  - Unsigned core operates on magnitudes.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
  - MULH: both operands signed. MULHSU: SrcA signed, SrcB unsigned. MULHU: both unsigned.
  - 64-bit product is negated when the sign flags differ.
  - DIV/REM truncate toward zero. Quotient is negated if the signs differ; remainder takes the dividend's sign.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (DIV and DIVU); remainder = SrcA (REM and REMU).
  - Signed overflow: DIV returns 0x80000000; REM returns 0.
- flush:
  - A synchronous edge with flush=1 forces IDLE from any state.
  - done is not pulsed and MDResult is unchanged.
  - flush has priority over start in the same cycle.
- Operands are sampled only at acceptance; later SrcA/SrcB/funct3 changes do not affect an in-flight op.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD -> done 33 cycles after start, MDResult=0xFFFFFFEB; Stall high for the 33 preceding cycles, low during done.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000; MULHSU SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF with done in the cycle after the start edge; REM 0xFFFFFFF9 / 0 -> 0xFFFFFFF9; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Start MUL 3x4, assert flush at CALC iteration 10 -> no done pulse, busy=0 next cycle, MDResult keeps its prior value; a following DIVU 9/3 returns 3 at normal latency.
- RST asserted mid-CALC -> next cycle busy=0, Stall=0, MDResult=0. start held high during CALC with changing operands -> ignored; the original result is returned.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: operand/result bundle between the execute stage and the
// iterative multiply/divide sequencer.
//   start, funct3, SrcA, SrcB, flush : requester -> sequencer
//   Stall, busy, done, MDResult      : sequencer -> requester
interface muldiv_seq_if #(
  parameter int D_WIDTH = 32
);
  logic               start;
  logic [2:0]         funct3;
  logic [D_WIDTH-1:0] SrcA;
  logic [D_WIDTH-1:0] SrcB;
  logic               flush;
  logic               Stall;
  logic               busy;
  logic               done;
  logic [D_WIDTH-1:0] MDResult;

  modport master (
    output start, funct3, SrcA, SrcB, flush,
    input  Stall, busy, done, MDResult
  );

  modport slave (
    input  start, funct3, SrcA, SrcB, flush,
    output Stall, busy, done, MDResult
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// One operation takes 32 shift-add (multiply) or restoring (divide) iterations
// on operand magnitudes; signs are applied when the result is registered.
//   CLK      : clock, rising edge
//   RST      : synchronous active-high reset
//   bus      : muldiv_seq_if.slave (start/funct3/SrcA/SrcB/flush in,
//              Stall/busy/done/MDResult out)
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// CALC  | one iteration per cycle, counter 0..31
// DONE  | done pulse, MDResult valid; returns to IDLE
module muldiv_seq #(
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 5
) (
  input  logic         CLK,
  input  logic         RST,
  muldiv_seq_if.slave  bus
);
  localparam int P_WIDTH = 2 * D_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(D_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_nx;
  logic [2:0]           op;
  logic                 neg_q;     // quotient / product negate
  logic                 neg_r;     // remainder negate (dividend sign)
  logic [CNT_WIDTH-1:0] cnt;
  logic [P_WIDTH-1:0]   p;         // mul: {partial, multiplier}; div: {rem, quot}
  logic [D_WIDTH-1:0]   mag;       // mul: multiplicand; div: divisor
  logic [D_WIDTH-1:0]   md_result;

  // Acceptance decode
  logic               accept, a_signed, b_signed, sa, sb, is_div;
  logic               div_zero, div_ovf, special;
  logic [D_WIDTH-1:0] mag_a, mag_b, special_res;

  assign accept   = (state == IDLE) && bus.start && !bus.flush;
  assign is_div   = bus.funct3[2];
  assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                    (bus.funct3 == 3'b110);
  assign sa       = a_signed && bus.SrcA[D_WIDTH-1];
  assign sb       = b_signed && bus.SrcB[D_WIDTH-1];
  assign mag_a    = sa ? -bus.SrcA : bus.SrcA;
  assign mag_b    = sb ? -bus.SrcB : bus.SrcB;
  assign div_zero = is_div && (bus.SrcB == '0);
  assign div_ovf  = is_div && !bus.funct3[0] &&
                    (bus.SrcA == {1'b1, {(D_WIDTH-1){1'b0}}}) &&
                    (bus.SrcB == {D_WIDTH{1'b1}});
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = bus.funct3[1] ? bus.SrcA : {D_WIDTH{1'b1}};
    else if (div_ovf)
      special_res = bus.funct3[1] ? '0 : {1'b1, {(D_WIDTH-1){1'b0}}};
  end

  // One iteration of the shared datapath
  logic [D_WIDTH:0]   mul_sum, shift_rem;
  logic               ge;
  logic [D_WIDTH-1:0] rem_new, q_fix, r_fix, final_res;
  logic [P_WIDTH-1:0] p_next, prod;

  assign mul_sum   = {1'b0, p[P_WIDTH-1:D_WIDTH]} + (p[0] ? {1'b0, mag} : '0);
  assign shift_rem = p[P_WIDTH-1:D_WIDTH-1];
  assign ge        = shift_rem >= {1'b0, mag};
  // rem < divisor, so the difference always fits in D_WIDTH bits
  assign rem_new   = ge ? (shift_rem[D_WIDTH-1:0] - mag) : shift_rem[D_WIDTH-1:0];
  assign p_next    = op[2] ? {rem_new, p[D_WIDTH-2:0], ge}
                           : {mul_sum, p[D_WIDTH-1:1]};

  assign prod  = neg_q ? -p_next : p_next;
  assign q_fix = neg_q ? -p_next[D_WIDTH-1:0] : p_next[D_WIDTH-1:0];
  assign r_fix = neg_r ? -p_next[P_WIDTH-1:D_WIDTH] : p_next[P_WIDTH-1:D_WIDTH];

  always_comb begin
    final_res = '0;
    if (op[2])
      final_res = op[1] ? r_fix : q_fix;
    else
      final_res = (op[1:0] == 2'b00) ? prod[D_WIDTH-1:0] : prod[P_WIDTH-1:D_WIDTH];
  end

  // FSM
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush) state_nx = IDLE;
  end

  // Datapath
  always_ff @(posedge CLK) begin
    if (RST) begin
      op        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
      p         <= '0;
      mag       <= '0;
      md_result <= '0;
    end else if (!bus.flush) begin
      if (accept) begin
        op    <= bus.funct3;
        neg_q <= sa ^ sb;
        neg_r <= sa;
        cnt   <= '0;
        p     <= {{D_WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
        mag   <= is_div ? mag_b : mag_a;
        if (special) md_result <= special_res;
      end else if (state == CALC) begin
        p   <= p_next;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) md_result <= final_res;
      end
    end
  end

  assign bus.Stall    = accept || (state == CALC);
  assign bus.busy     = (state == CALC) || (state == DONE);
  assign bus.done     = (state == DONE);
  assign bus.MDResult = md_result;
endmodule
